mmu_unit: RTL and testbench

MMU_UNIT -- requirements
Module: mmu_unit

---
 rtl/mmu_unit_pkg.sv | 81 ++++++++
 rtl/mmu_unit.sv | 210 +++++++++++++++++++++
 tb/tb_mmu_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmu_unit_pkg
// Description : Shared constants, FSM encoding and the permission check for
//               the Sv32 single-entry MMU.
// Revision    : 1.0 - initial release
// ============================================================================
package mmu_unit_pkg;

   // Bit positions inside a Sv32 page-table entry
   localparam int c_PTE_V = 0;
   localparam int c_PTE_R = 1;
   localparam int c_PTE_W = 2;
   localparam int c_PTE_X = 3;
   localparam int c_PTE_U = 4;
   localparam int c_PTE_G = 5;
   localparam int c_PTE_A = 6;
   localparam int c_PTE_D = 7;

   // Bit positions inside the compacted flag vector kept for a cached leaf
   localparam int c_FL_R = 0;
   localparam int c_FL_W = 1;
   localparam int c_FL_X = 2;
   localparam int c_FL_U = 3;
   localparam int c_FL_A = 4;
   localparam int c_FL_D = 5;

   // Privilege encodings
   localparam logic [1:0] c_PRIV_U = 2'b00;
   localparam logic [1:0] c_PRIV_S = 2'b01;
   localparam logic [1:0] c_PRIV_M = 2'b11;

   // Pipeline hazard codes
   localparam logic [3:0] c_HZ_FLUSH     = 4'b0001;
   localparam logic [3:0] c_HZ_STALL_MMU = 4'b0010;

   // Page-walk state machine
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_L1_REQ = 3'd1,
      ST_L0_REQ = 3'd2,
      ST_GAP    = 3'd3,
      ST_DONE   = 3'd4
   } mmu_state_t;

   // Returns 1 when the leaf permits the requested access at this privilege
   function automatic logic perm_ok(
      input logic       r,
      input logic       w,
      input logic       x,
      input logic       u,
      input logic       a,
      input logic       d,
      input logic       is_load,
      input logic       is_store,
      input logic       is_inst,
      input logic [1:0] prv,
      input logic       sum
   );
      logic ok;
      ok = 1'b1;
      if (is_inst  && !x)        ok = 1'b0;
      if (is_load  && !r)        ok = 1'b0;
      if (is_store && !(r && w)) ok = 1'b0;
      if (u) begin
         // supervisor never executes user pages; data access needs SUM
         if (prv == c_PRIV_S) begin
            if (is_inst)   ok = 1'b0;
            else if (!sum) ok = 1'b0;
         end
      end else if (prv == c_PRIV_U) begin
         ok = 1'b0;
      end
      // accessed/dirty are never updated by hardware, so clear bits fault
      if (!a)              ok = 1'b0;
      if (is_store && !d)  ok = 1'b0;
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mmu_unit.sv
`default_nettype none
// ============================================================================
// Module      : mmu_unit
// Description : Sv32 address translation with a single cached entry and a
//               two-level hardware page-table walker.
// Revision    : 1.0 - initial release
// ============================================================================
module mmu_unit
   import mmu_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] VPC,
   input  logic [31:0] csr_satp,
   input  logic [1:0]  priv,
   input  logic        sstatus_sum,
   input  logic        access_is_load,
   input  logic        access_is_store,
   input  logic        access_is_inst,
   input  logic [3:0]  hazard_signal,
   input  logic        LFM_resolved,
   input  logic [7:0]  b1,
   input  logic [7:0]  b2,
   input  logic [7:0]  b3,
   input  logic [7:0]  b4,
   output logic [31:0] LFM,
   output logic        LFM_enable,
   output logic [31:0] PC,
   output logic        stall,
   output logic        instr_fault_mmu,
   output logic        load_fault_mmu,
   output logic        store_fault_mmu,
   output logic [31:0] faulting_va
);

   mmu_state_t  r_state;
   mmu_state_t  w_next;

   // walk scratch registers
   logic [19:0] r_walk_vpn;
   logic [31:0] r_walk_satp;
   logic [19:0] r_walk_ppn;
   logic [5:0]  r_walk_flags;
   logic        r_walk_super;
   logic        r_walk_fault;
   logic [31:0] r_lfm;

   // cached translation
   logic        r_ent_valid;
   logic [19:0] r_ent_vpn;
   logic [31:0] r_ent_satp;
   logic [19:0] r_ent_ppn;
   logic [5:0]  r_ent_flags;
   logic        r_ent_super;
   logic        r_ent_fault;

   logic [31:0] r_fva;

   logic        w_bare;
   logic        w_access;
   logic        w_hit;
   logic        w_perm_ok;
   logic        w_fault_hit;
   logic        w_start;
   logic        w_flush;
   logic [31:0] w_pte;
   logic [5:0]  w_pte_flags;
   logic        w_pte_bad;
   logic        w_pte_leaf;
   logic        w_misaligned;
   logic [31:0] w_l1_addr;
   logic [31:0] w_l0_addr;
   logic        w_unused_pte_bits;

   assign w_pte        = {b4, b3, b2, b1};
   assign w_pte_flags  = {w_pte[c_PTE_D], w_pte[c_PTE_A], w_pte[c_PTE_U],
                          w_pte[c_PTE_X], w_pte[c_PTE_W], w_pte[c_PTE_R]};
   assign w_pte_bad    = !w_pte[c_PTE_V] || (!w_pte[c_PTE_R] && w_pte[c_PTE_W]);
   assign w_pte_leaf   = w_pte[c_PTE_R] || w_pte[c_PTE_X];
   assign w_misaligned = (w_pte[19:10] != 10'd0);
   // upper PPN bits, RSW and G do not influence a 32-bit translation
   assign w_unused_pte_bits = ^{w_pte[31:30], w_pte[9:8], w_pte[c_PTE_G]};

   // addresses are the 34-bit physical form truncated to 32 bits
   assign w_l1_addr = {csr_satp[19:0], 12'd0} + {20'd0, VPC[31:22], 2'b00};
   assign w_l0_addr = {w_pte[29:10], 12'd0} + {20'd0, r_walk_vpn[9:0], 2'b00};

   assign w_bare   = !csr_satp[31] || (priv == c_PRIV_M);
   assign w_access = access_is_load || access_is_store || access_is_inst;
   assign w_flush  = (hazard_signal == c_HZ_FLUSH);
   assign w_hit    = !w_bare && r_ent_valid && (r_ent_vpn == VPC[31:12]) &&
                     (r_ent_satp == csr_satp) && w_access;
   assign w_start  = (r_state == ST_IDLE) && !w_bare && w_access && !w_hit;

   // permissions are re-evaluated against the cached leaf for every access,
   // so a fault tracks the current access type and privilege
   assign w_perm_ok = perm_ok(r_ent_flags[c_FL_R], r_ent_flags[c_FL_W],
                              r_ent_flags[c_FL_X], r_ent_flags[c_FL_U],
                              r_ent_flags[c_FL_A], r_ent_flags[c_FL_D],
                              access_is_load, access_is_store, access_is_inst,
                              priv, sstatus_sum);
   assign w_fault_hit = w_hit && (r_ent_fault || !w_perm_ok);

   assign stall           = rst && !w_bare && w_access && !w_hit;
   assign instr_fault_mmu = w_fault_hit && access_is_inst;
   assign load_fault_mmu  = w_fault_hit && access_is_load;
   assign store_fault_mmu = w_fault_hit && access_is_store;
   assign faulting_va     = w_fault_hit ? VPC : r_fva;
   assign LFM             = r_lfm;
   assign LFM_enable      = (r_state == ST_L1_REQ) || (r_state == ST_L0_REQ);
   assign PC = w_bare      ? VPC :
               r_ent_super ? {r_ent_ppn[19:10], VPC[21:0]} :
                             {r_ent_ppn, VPC[11:0]};

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   // next-state: flush aborts any walk in progress
   always_comb begin
      w_next = r_state;
      if (r_state != ST_IDLE && w_flush) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:   if (w_start) w_next = ST_L1_REQ;
            ST_L1_REQ: if (LFM_resolved)
                          w_next = (w_pte_bad || w_pte_leaf) ? ST_DONE : ST_GAP;
            ST_GAP:    w_next = ST_L0_REQ;
            ST_L0_REQ: if (LFM_resolved) w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
         endcase
      end
   end

   // walk datapath: latch request, PTE fetch addresses and walk result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_walk_vpn   <= 20'd0;
         r_walk_satp  <= 32'd0;
         r_walk_ppn   <= 20'd0;
         r_walk_flags <= 6'd0;
         r_walk_super <= 1'b0;
         r_walk_fault <= 1'b0;
         r_lfm        <= 32'd0;
      end else if (!(r_state != ST_IDLE && w_flush)) begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_walk_vpn  <= VPC[31:12];
                  r_walk_satp <= csr_satp;
                  r_lfm       <= w_l1_addr;
               end
            end
            ST_L1_REQ: begin
               if (LFM_resolved) begin
                  r_walk_ppn   <= w_pte[29:10];
                  r_walk_flags <= w_pte_flags;
                  r_walk_super <= 1'b1;
                  r_walk_fault <= w_pte_bad || (w_pte_leaf && w_misaligned);
                  if (!w_pte_bad && !w_pte_leaf) r_lfm <= w_l0_addr;
               end
            end
            ST_L0_REQ: begin
               if (LFM_resolved) begin
                  r_walk_ppn   <= w_pte[29:10];
                  r_walk_flags <= w_pte_flags;
                  r_walk_super <= 1'b0;
                  r_walk_fault <= w_pte_bad || !w_pte_leaf;
               end
            end
            default: ;
         endcase
      end
   end

   // translation entry: filled from DONE, dropped on any satp change
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ent_valid <= 1'b0;
         r_ent_vpn   <= 20'd0;
         r_ent_satp  <= 32'd0;
         r_ent_ppn   <= 20'd0;
         r_ent_flags <= 6'd0;
         r_ent_super <= 1'b0;
         r_ent_fault <= 1'b0;
      end else if (r_state == ST_DONE && !w_flush) begin
         r_ent_valid <= 1'b1;
         r_ent_vpn   <= r_walk_vpn;
         r_ent_satp  <= r_walk_satp;
         r_ent_ppn   <= r_walk_ppn;
         r_ent_flags <= r_walk_flags;
         r_ent_super <= r_walk_super;
         r_ent_fault <= r_walk_fault;
      end else if (r_ent_valid && (csr_satp != r_ent_satp)) begin
         r_ent_valid <= 1'b0;
      end
   end

   // remember the last faulting address for when no fault is active
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)             r_fva <= 32'd0;
      else if (w_fault_hit) r_fva <= VPC;
   end

endmodule
`default_nettype wire

// File: tb/tb_mmu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmu_unit
// Description : Self-checking bench for mmu_unit with a table of translation
//               vectors, a PTE memory responder and abort sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmu_unit;
   import mmu_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] VPC, csr_satp;
   logic [1:0]  priv;
   logic        sstatus_sum, access_is_load, access_is_store, access_is_inst;
   logic [3:0]  hazard_signal;
   logic        LFM_resolved;
   logic [7:0]  b1, b2, b3, b4;
   logic [31:0] LFM, PC, faulting_va;
   logic        LFM_enable, stall, instr_fault_mmu, load_fault_mmu, store_fault_mmu;

   mmu_unit dut (
      .clk(clk), .rst(rst), .VPC(VPC), .csr_satp(csr_satp), .priv(priv),
      .sstatus_sum(sstatus_sum), .access_is_load(access_is_load),
      .access_is_store(access_is_store), .access_is_inst(access_is_inst),
      .hazard_signal(hazard_signal), .LFM_resolved(LFM_resolved),
      .b1(b1), .b2(b2), .b3(b3), .b4(b4), .LFM(LFM), .LFM_enable(LFM_enable),
      .PC(PC), .stall(stall), .instr_fault_mmu(instr_fault_mmu),
      .load_fault_mmu(load_fault_mmu), .store_fault_mmu(store_fault_mmu),
      .faulting_va(faulting_va)
   );

   always #5 clk = ~clk;

   // acc / flt encodings: {inst, store, load}
   typedef struct {
      logic [31:0] satp;
      logic [1:0]  prv;
      logic        sum;
      logic [31:0] vpc;
      logic [2:0]  acc;
      int          nlvl;
      logic [31:0] lfm1;
      logic [31:0] pte1;
      logic [31:0] lfm0;
      logic [31:0] pte0;
      logic [31:0] pc;
      logic [2:0]  flt;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [2:0]  flt;
      logic [31:0] va;
   } res_t;

   res_t        exp_q[$];
   logic [31:0] lfm_q[$];
   logic [31:0] pte_q[$];
   vec_t        vt[15];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic set_acc(input logic [2:0] a);
      {access_is_inst, access_is_store, access_is_load} = a;
   endtask

   // wait (bounded) for a PTE request, clearing any response pulse
   task automatic wait_en(input string name, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         LFM_resolved = 1'b0;
         if (LFM_enable) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=no_request required=request", name);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      res_t        e;
      int          nfetch, gap;
      bit          done;
      logic [31:0] p;
      csr_satp = v.satp; priv = v.prv; sstatus_sum = v.sum; VPC = v.vpc;
      set_acc(v.acc);
      e.pc = v.pc; e.flt = v.flt; e.va = v.vpc;
      exp_q.push_back(e);
      if (v.nlvl >= 1) begin lfm_q.push_back(v.lfm1); pte_q.push_back(v.pte1); end
      if (v.nlvl >= 2) begin lfm_q.push_back(v.lfm0); pte_q.push_back(v.pte0); end
      #2;
      chk($sformatf("v%0d stall_now", idx), {31'd0, stall}, (v.nlvl != 0) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d lfm_en_now", idx), {31'd0, LFM_enable}, 32'd0);
      nfetch = 0; gap = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         LFM_resolved = 1'b0;
         if (!stall) begin
            e = exp_q.pop_front();
            chk($sformatf("v%0d faults", idx),
                {29'd0, instr_fault_mmu, store_fault_mmu, load_fault_mmu}, {29'd0, e.flt});
            if (e.flt == 3'd0) chk($sformatf("v%0d pc", idx), PC, e.pc);
            else               chk($sformatf("v%0d faulting_va", idx), faulting_va, e.va);
            done = 1'b1;
         end else if (LFM_enable) begin
            if (lfm_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL v%0d unexpected_fetch actual=%h required=none", idx, LFM);
               p = 32'd0;
            end else begin
               chk($sformatf("v%0d lfm%0d", idx, nfetch), LFM, lfm_q.pop_front());
               p = pte_q.pop_front();
            end
            if (nfetch == 1) chk($sformatf("v%0d gap", idx), gap, 32'd1);
            {b4, b3, b2, b1} = p;
            LFM_resolved = 1'b1;
            nfetch++;
            gap = 0;
         end else if (nfetch > 0) begin
            gap++;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL v%0d timeout actual=stall required=result", idx);
         exp_q.delete();
      end
      chk($sformatf("v%0d fetches", idx), nfetch, v.nlvl);
      lfm_q.delete(); pte_q.delete();
      LFM_resolved = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      bit ok;
      vec_t v;
      //        satp          prv       sum vpc           acc   n  lfm1        pte1          lfm0        pte0          pc            flt
      vt[0]  = '{32'h0,        c_PRIV_S, 0, 32'h0000_1234, 3'b001, 0, 32'h0,      32'h0,        32'h0,      32'h0,        32'h0000_1234, 3'b000};
      vt[1]  = '{32'h8000_0001, c_PRIV_S, 0, 32'h0040_1ABC, 3'b001, 2, 32'h1004, 32'h0000_0801, 32'h2004, 32'h0000_8CC7, 32'h0002_3ABC, 3'b000};
      vt[2]  = '{32'h8000_0001, c_PRIV_S, 0, 32'h0040_1ABC, 3'b001, 0, 32'h0,    32'h0,        32'h0,    32'h0,        32'h0002_3ABC, 3'b000};
      vt[3]  = '{32'h8000_0001, c_PRIV_S, 0, 32'h0040_1ABC, 3'b010, 0, 32'h0,    32'h0,        32'h0,    32'h0,        32'h0002_3ABC, 3'b000};
      vt[4]  = '{32'h8000_0001, c_PRIV_S, 0, 32'h0040_2DEF, 3'b010, 2, 32'h1004, 32'h0000_0801, 32'h2008, 32'h0000_8CC3, 32'h0,         3'b010};
      vt[5]  = '{32'h8000_0001, c_PRIV_S, 0, 32'h0040_2DEF, 3'b001, 0, 32'h0,    32'h0,        32'h0,    32'h0,        32'h0002_3DEF, 3'b000};
      vt[6]  = '{32'h8000_0001, c_PRIV_S, 0, 32'h00C0_0123, 3'b001, 1, 32'h100C, 32'h0000_04CF, 32'h0,    32'h0,        32'h0,         3'b001};
      vt[7]  = '{32'h8000_0001, c_PRIV_S, 0, 32'h0080_0456, 3'b001, 1, 32'h1008, 32'h0010_00CF, 32'h0,    32'h0,        32'h0040_0456, 3'b000};
      vt[8]  = '{32'h8000_0001, c_PRIV_U, 0, 32'h0080_0456, 3'b001, 0, 32'h0,    32'h0,        32'h0,    32'h0,        32'h0,         3'b001};
      vt[9]  = '{32'h8000_0001, c_PRIV_S, 0, 32'h0100_0000, 3'b001, 1, 32'h1010, 32'h0020_00DF, 32'h0,    32'h0,        32'h0,         3'b001};
      vt[10] = '{32'h8000_0001, c_PRIV_S, 1, 32'h0100_0000, 3'b001, 0, 32'h0,    32'h0,        32'h0,    32'h0,        32'h0080_0000, 3'b000};
      vt[11] = '{32'h8000_0001, c_PRIV_S, 1, 32'h0100_0000, 3'b100, 0, 32'h0,    32'h0,        32'h0,    32'h0,        32'h0,         3'b100};
      vt[12] = '{32'h8000_0001, c_PRIV_S, 0, 32'h0140_0000, 3'b001, 1, 32'h1014, 32'h0000_0000, 32'h0,    32'h0,        32'h0,         3'b001};
      vt[13] = '{32'h8000_0001, c_PRIV_S, 0, 32'h0040_3000, 3'b001, 2, 32'h1004, 32'h0000_0801, 32'h200C, 32'h0000_8C07, 32'h0,         3'b001};
      vt[14] = '{32'h8000_0001, c_PRIV_M, 0, 32'hDEAD_BEEF, 3'b001, 0, 32'h0,    32'h0,        32'h0,    32'h0,        32'hDEAD_BEEF, 3'b000};

      // reset with a translating load pending
      rst = 1'b0; csr_satp = 32'h8000_0001; priv = c_PRIV_S; sstatus_sum = 1'b0;
      VPC = 32'h0040_1ABC; set_acc(3'b001); hazard_signal = 4'd0;
      LFM_resolved = 1'b0; {b4, b3, b2, b1} = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst stall", {31'd0, stall}, 32'd0);
      chk("rst lfm_en", {31'd0, LFM_enable}, 32'd0);
      chk("rst lfm", LFM, 32'd0);
      chk("rst fva", faulting_va, 32'd0);
      chk("rst faults", {29'd0, instr_fault_mmu, store_fault_mmu, load_fault_mmu}, 32'd0);
      set_acc(3'b000);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 15; i++) run_vec(i, vt[i]);

      // faults persist while the faulting hit persists (entry from vt[13])
      priv = c_PRIV_S; VPC = 32'h0040_3000; set_acc(3'b001);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("persist%0d load_fault", i), {31'd0, load_fault_mmu}, 32'd1);
         chk($sformatf("persist%0d stall", i), {31'd0, stall}, 32'd0);
      end
      set_acc(3'b010);
      @(negedge clk);
      chk("retype faults", {29'd0, instr_fault_mmu, store_fault_mmu, load_fault_mmu}, 32'd2);
      set_acc(3'b000);
      @(negedge clk);
      chk("noacc faults", {29'd0, instr_fault_mmu, store_fault_mmu, load_fault_mmu}, 32'd0);

      // FLUSH during the level-0 request
      VPC = 32'h0040_5000; set_acc(3'b001);
      wait_en("flush l1_wait", ok);
      chk("flush l1 lfm", LFM, 32'h1004);
      {b4, b3, b2, b1} = 32'h0000_0801; LFM_resolved = 1'b1;
      wait_en("flush l0_wait", ok);
      chk("flush l0 lfm", LFM, 32'h2014);
      hazard_signal = c_HZ_FLUSH;
      @(negedge clk);
      chk("flush lfm_en", {31'd0, LFM_enable}, 32'd0);
      hazard_signal = 4'd0; set_acc(3'b000);
      @(negedge clk);
      v = '{32'h8000_0001, c_PRIV_S, 0, 32'h0040_5000, 3'b001, 2, 32'h1004, 32'h0000_0801,
            32'h2014, 32'h0000_8CC7, 32'h0002_3000, 3'b000};
      run_vec(20, v);

      // reset during the level-1 request
      VPC = 32'h0040_6000; set_acc(3'b001);
      wait_en("rstwalk l1_wait", ok);
      rst = 1'b0;
      #1;
      chk("rstwalk lfm_en", {31'd0, LFM_enable}, 32'd0);
      chk("rstwalk stall", {31'd0, stall}, 32'd0);
      chk("rstwalk lfm", LFM, 32'd0);
      @(negedge clk);
      set_acc(3'b000);
      rst = 1'b1;
      @(negedge clk);
      run_vec(21, v);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
